// File: rtl/trans_aff_pkg.sv
// Shared display codes and FSM encoding for the sequential binary-to-7-seg translator.
package trans_aff_pkg;

    localparam logic [3:0] CODE_ZERO  = 4'd10;
    localparam logic [3:0] CODE_D     = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd12;
    localparam logic [3:0] CODE_DASH  = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FMT   = 2'd2
    } state_t;

endpackage

// File: rtl/trans_aff_add3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more before a shift.
module trans_aff_add3 (
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/trans_aff_bcd_seq.sv
// Iterative (one bit per clock) binary-to-BCD converter with blanking, overflow
// dashes and a prefix slot, feeding the 7-seg decoders.
module trans_aff_bcd_seq
    import trans_aff_pkg::*;
#(
    parameter int IN_W = 7,
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IN_W-1:0]   value,
    input  logic              prefix_en,
    output logic [4*NDIG-1:0] id_dig,
    output logic [3:0]        id_d,
    output logic              busy,
    output logic              done
);

    localparam int          CNT_W = $clog2(IN_W + 1);
    localparam int          BCD_W = 4 * NDIG;
    localparam logic [63:0] LIMIT = 64'(10 ** NDIG);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    sh;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   fmt_dig;
    logic               ovf;
    logic               pfx;
    logic [3:0]         nib;
    logic               seen;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        trans_aff_add3 u_add3 (
            .nib (bcd[4*g +: 4]),
            .adj (bcd_adj[4*g +: 4])
        );
    end

    // Control and output registers; a reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            id_dig <= {NDIG{CODE_BLANK}};
            id_d   <= CODE_BLANK;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(IN_W - 1)) state <= FMT;
                end
                FMT: begin
                    id_dig <= fmt_dig;
                    id_d   <= pfx ? CODE_D : CODE_BLANK;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operands are only consumed while the FSM walks SHIFT/FMT.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            sh  <= value;
            bcd <= '0;
            pfx <= prefix_en;
            ovf <= (64'(value) >= LIMIT);
        end else if (state == SHIFT) begin
            bcd <= {bcd_adj[BCD_W-2:0], sh[IN_W-1]};
            sh  <= sh << 1;
        end
    end

    // Walk from the most significant slot down so zeros above the first
    // non-zero digit blank out; the units slot always shows a digit.
    always_comb begin
        fmt_dig = '0;
        seen    = 1'b0;
        nib     = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (ovf) begin
                fmt_dig[4*i +: 4] = CODE_DASH;
            end else if (nib != 4'd0 || seen || i == 0) begin
                seen              = 1'b1;
                fmt_dig[4*i +: 4] = (nib == 4'd0) ? CODE_ZERO : nib;
            end else begin
                fmt_dig[4*i +: 4] = CODE_BLANK;
            end
        end
    end

endmodule
